// File: rtl/platform_scroller.sv
// platform_scroller -- owns the platform slot table for the jump physics and
// color mapper. On every frame strobe it derives a scroll amount from the
// doodle height, walks the table one slot per clock shifting platforms down,
// respawns platforms that fall off the bottom at the top with a pseudo-random
// X, then pulses loadplat_o.
//
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   frame_clk_i    frame strobe (VGA_VS), rising edge starts an update
//   doodle_y_i     doodle top Y in pixels
//   rising_i       doodle moving up this frame
//   plat_x_o       packed slot X, slot k at [10k+9:10k]
//   plat_y_o       packed slot Y, same packing
//   scroll_amt_o   scroll applied by the most recent update
//   loadplat_o     one-cycle pulse when the table update completes
//   busy_o         table walk in progress (INIT/SCROLL, through DONE)
//   frame_miss_o   sticky: a frame edge arrived while not waiting
//   score_o        cumulative scrolled pixels
//
// Optional feature: define PLAT_SCORE_EN to keep a saturating score counter;
// otherwise score_o is tied to zero.
module platform_scroller #(
   parameter int          NUM_PLAT    = 15,
   parameter int          SCREEN_W    = 640,
   parameter int          SCREEN_H    = 480,
   parameter int          PLAT_W      = 64,
   parameter int          SCROLL_LINE = 160,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     frame_clk_i,
   input  logic [9:0]               doodle_y_i,
   input  logic                     rising_i,
   output logic [10*NUM_PLAT-1:0]   plat_x_o,
   output logic [10*NUM_PLAT-1:0]   plat_y_o,
   output logic [4:0]               scroll_amt_o,
   output logic                     loadplat_o,
   output logic                     busy_o,
   output logic                     frame_miss_o,
   output logic [15:0]              score_o
);

   localparam int KW     = $clog2(NUM_PLAT);
   localparam int YSTEP  = SCREEN_H / NUM_PLAT;
   localparam int XRANGE = SCREEN_W - PLAT_W;

   typedef enum logic [1:0] {S_INIT, S_WAIT, S_SCROLL, S_DONE} state_e;

   state_e                        state_q, state_d;
   logic [KW-1:0]                 k_q, k_d;
   logic [15:0]                   lfsr_q, lfsr_d;
   logic [NUM_PLAT-1:0][9:0]      x_q, x_d, y_q, y_d;
   logic [4:0]                    amt_q, amt_d;
   logic                          fc_q, loadplat_q, busy_q, miss_q;

   logic                          edge_w;
   logic [15:0]                   lfsr_next;
   logic [9:0]                    resp_x;
   logic [9:0]                    diff;
   logic [4:0]                    req_amt;
   logic [10:0]                   t;
   logic                          last_k;

   assign edge_w    = frame_clk_i & ~fc_q;
   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // one conditional subtract folds 0..1023 into 0..XRANGE-1 for the defaults
   assign resp_x    = (lfsr_q[9:0] >= 10'(XRANGE)) ? lfsr_q[9:0] - 10'(XRANGE) : lfsr_q[9:0];
   assign diff      = 10'(SCROLL_LINE) - doodle_y_i;
   assign req_amt   = (rising_i && (doodle_y_i < 10'(SCROLL_LINE)))
                      ? ((diff > 10'd31) ? 5'd31 : diff[4:0]) : 5'd0;
   assign t         = {1'b0, y_q[k_q]} + {6'b0, amt_q};
   assign last_k    = (k_q == KW'(NUM_PLAT - 1));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      lfsr_d  = lfsr_q;
      x_d     = x_q;
      y_d     = y_q;
      amt_d   = amt_q;
      case (state_q)
         S_INIT: begin
            x_d[k_q] = resp_x;
            y_d[k_q] = 10'(int'(k_q) * YSTEP);
            lfsr_d   = lfsr_next;
            k_d      = last_k ? '0 : k_q + 1'b1;
            if (last_k) state_d = S_DONE;
         end
         S_WAIT: begin
            if (edge_w) begin
               amt_d   = req_amt;
               k_d     = '0;
               state_d = S_SCROLL;
            end
         end
         S_SCROLL: begin
            if (t >= 11'(SCREEN_H)) begin
               y_d[k_q] = 10'(t - 11'(SCREEN_H));
               x_d[k_q] = resp_x;
               lfsr_d   = lfsr_next;
            end else begin
               y_d[k_q] = t[9:0];
            end
            k_d = last_k ? '0 : k_q + 1'b1;
            if (last_k) state_d = S_DONE;
         end
         default: state_d = S_WAIT;  // S_DONE
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_INIT;
         k_q        <= '0;
         lfsr_q     <= LFSR_SEED;
         x_q        <= '0;
         y_q        <= '0;
         amt_q      <= '0;
         fc_q       <= 1'b0;
         loadplat_q <= 1'b0;
         busy_q     <= 1'b1;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         lfsr_q     <= lfsr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         amt_q      <= amt_d;
         fc_q       <= frame_clk_i;
         loadplat_q <= (state_d == S_DONE);
         // busy holds through the DONE cycle and drops only on WAIT entry
         busy_q     <= (state_d != S_WAIT);
         if (edge_w && state_q != S_WAIT) miss_q <= 1'b1;
      end
   end

`ifdef PLAT_SCORE_EN
   logic [15:0] score_q, score_d;
   logic [16:0] score_sum;

   assign score_sum = {1'b0, score_q} + {12'b0, req_amt};

   always_comb begin
      score_d = score_q;
      if (state_q == S_WAIT && edge_w)
         score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) score_q <= '0;
      else         score_q <= score_d;
   end

   assign score_o = score_q;
`else
   assign score_o = '0;
`endif

   assign plat_x_o     = x_q;
   assign plat_y_o     = y_q;
   assign scroll_amt_o = amt_q;
   assign loadplat_o   = loadplat_q;
   assign busy_o       = busy_q;
   assign frame_miss_o = miss_q;

endmodule
